l2_amo_ctrl: RTL and testbench

- Sequencer that executes one atomic memory operation (AMO) at a time inside the L2 pipeline.
- Accepts an AMO request, reads the target data line from the L2 data array, and presents the line and CPU operand to the downstream AMO ALU.
- Writes the ALU's merged line back to the array and returns the pre-AMO line to the requester.
- Sits directly upstream of, and wraps, the AMO ALU: it owns all ALU inputs and consumes `amo_result`.

---
 rtl/l2_amo_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_l2_amo_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_amo_ctrl.sv
// l2_amo_ctrl: runs one atomic memory operation at a time inside the L2.
// It reads the target line, feeds the line and the CPU operand to the AMO ALU,
// writes the merged line back (unless the op is NOP) and returns the pre-AMO line.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               AMO request (valid/ready), op/addr/size/operand line
//   arr_*               data-array read/write strobes, address, data
//   alu_*               operands to the AMO ALU, alu_result returned one cycle later
//   resp_*              response (valid/ready): pre-AMO line, abort flag
//   busy                operation in flight
//
// Optional build macro L2_AMO_CTRL_TIMEOUT_EN: abort a read that does not return
// within TIMEOUT_CYCLES WAIT cycles (resp_err=1, resp_data=0, no write).

`ifndef L2_AMO_ALU_OP_WIDTH
`define L2_AMO_ALU_OP_WIDTH 4
`endif
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 40
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif
`ifndef L2_DATA_DATA_WIDTH
`define L2_DATA_DATA_WIDTH 128
`endif
`ifndef L2_AMO_ALU_NOP
`define L2_AMO_ALU_NOP 0
`endif

module l2_amo_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_val,
  output logic                              req_rdy,
  input  logic [`L2_AMO_ALU_OP_WIDTH-1:0]   req_op,
  input  logic [`PHY_ADDR_WIDTH-1:0]        req_addr,
  input  logic [`MSG_DATA_SIZE_WIDTH-1:0]   req_size,
  input  logic [`L2_DATA_DATA_WIDTH-1:0]    req_data,
  output logic                              arr_rd_en,
  output logic                              arr_wr_en,
  output logic [`PHY_ADDR_WIDTH-1:0]        arr_addr,
  input  logic [`L2_DATA_DATA_WIDTH-1:0]    arr_rd_data,
  input  logic                              arr_rd_data_val,
  output logic [`L2_DATA_DATA_WIDTH-1:0]    arr_wr_data,
  output logic [`L2_AMO_ALU_OP_WIDTH-1:0]   alu_op,
  output logic [`PHY_ADDR_WIDTH-1:0]        alu_addr,
  output logic [`MSG_DATA_SIZE_WIDTH-1:0]   alu_size,
  output logic [`L2_DATA_DATA_WIDTH-1:0]    alu_mem_operand,
  output logic [`L2_DATA_DATA_WIDTH-1:0]    alu_cpu_operand,
  input  logic [`L2_DATA_DATA_WIDTH-1:0]    alu_result,
  output logic                              resp_val,
  input  logic                              resp_rdy,
  output logic [`L2_DATA_DATA_WIDTH-1:0]    resp_data,
  output logic                              resp_err,
  output logic                              busy
);

  localparam int unsigned OP_W   = `L2_AMO_ALU_OP_WIDTH;
  localparam int unsigned ADDR_W = `PHY_ADDR_WIDTH;
  localparam int unsigned SIZE_W = `MSG_DATA_SIZE_WIDTH;
  localparam int unsigned DATA_W = `L2_DATA_DATA_WIDTH;
  localparam logic [OP_W-1:0] OP_NOP = OP_W'(`L2_AMO_ALU_NOP);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                accept, capture, tmo;
  logic                tmo_hit;
  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [SIZE_W-1:0]   size_q;
  logic [DATA_W-1:0]   cpu_q;
  logic [DATA_W-1:0]   mem_q;
  logic                req_rdy_q, rd_en_q, wr_en_q, resp_val_q, busy_q;

`ifdef L2_AMO_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // cnt_q counts completed WAIT cycles; the last allowed cycle is TIMEOUT_CYCLES-1
  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter (zero outside WAIT, so it is clear on every entry) and abort flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_WAIT) cnt_q <= CNT_W'(cnt_q + 1'b1);
      else                   cnt_q <= '0;
      if (accept)   err_q <= 1'b0;
      else if (tmo) err_q <= 1'b1;
    end
  end

  assign resp_err = err_q;
`else
  assign tmo_hit  = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Next-state logic; read data wins over a same-cycle timeout
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_val) begin
          accept  = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        if (arr_rd_data_val) begin
          capture = 1'b1;
          state_d = S_EXEC;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = S_RESP;
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_RESP;
      S_RESP: begin
        if (resp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, holding registers and registered control outputs (decoded from next state)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      cpu_q      <= '0;
      mem_q      <= '0;
      req_rdy_q  <= 1'b1;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      resp_val_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_rdy_q  <= (state_d == S_IDLE);
      rd_en_q    <= (state_d == S_RD);
      wr_en_q    <= (state_d == S_WB) && (op_q != OP_NOP);
      resp_val_q <= (state_d == S_RESP);
      busy_q     <= (state_d != S_IDLE);
      if (accept) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        size_q <= req_size;
        cpu_q  <= req_data;
      end
      if (capture)  mem_q <= arr_rd_data;
      else if (tmo) mem_q <= '0;
    end
  end

  assign req_rdy         = req_rdy_q;
  assign arr_rd_en       = rd_en_q;
  assign arr_wr_en       = wr_en_q;
  assign arr_addr        = addr_q;
  // The ALU result is only meaningful in WB; the write bus is zero otherwise
  assign arr_wr_data     = wr_en_q ? alu_result : '0;
  assign alu_op          = op_q;
  assign alu_addr        = addr_q;
  assign alu_size        = size_q;
  assign alu_mem_operand = mem_q;
  assign alu_cpu_operand = cpu_q;
  assign resp_val        = resp_val_q;
  assign resp_data       = mem_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_l2_amo_ctrl.sv
// Scoreboard bench for l2_amo_ctrl: a behavioural array and AMO ALU surround the DUT,
// the driver pushes hand-computed expectations, a negedge monitor pops and compares.

`ifndef L2_AMO_ALU_OP_WIDTH
`define L2_AMO_ALU_OP_WIDTH 4
`endif
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 40
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif
`ifndef L2_DATA_DATA_WIDTH
`define L2_DATA_DATA_WIDTH 128
`endif

module tb_l2_amo_ctrl;

  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_MAX = 4'd5, OP_MAXU = 4'd6, OP_MIN = 4'd7,
                         OP_MINU = 4'd8;
  localparam logic [2:0] SZ1 = 3'b001, SZ2 = 3'b010, SZ4 = 3'b011, SZ8 = 3'b100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_val = 1'b0;
  logic         req_rdy;
  logic [3:0]   req_op = '0;
  logic [39:0]  req_addr = '0;
  logic [2:0]   req_size = '0;
  logic [127:0] req_data = '0;
  logic         arr_rd_en, arr_wr_en;
  logic [39:0]  arr_addr;
  logic [127:0] arr_rd_data = '0;
  logic         arr_rd_data_val = 1'b0;
  logic [127:0] arr_wr_data;
  logic [3:0]   alu_op;
  logic [39:0]  alu_addr;
  logic [2:0]   alu_size;
  logic [127:0] alu_mem_operand, alu_cpu_operand, alu_result;
  logic         resp_val;
  logic         resp_rdy = 1'b1;
  logic [127:0] resp_data;
  logic         resp_err;
  logic         busy;

  l2_amo_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_addr(req_addr),
    .req_size(req_size), .req_data(req_data),
    .arr_rd_en(arr_rd_en), .arr_wr_en(arr_wr_en), .arr_addr(arr_addr),
    .arr_rd_data(arr_rd_data), .arr_rd_data_val(arr_rd_data_val), .arr_wr_data(arr_wr_data),
    .alu_op(alu_op), .alu_addr(alu_addr), .alu_size(alu_size),
    .alu_mem_operand(alu_mem_operand), .alu_cpu_operand(alu_cpu_operand),
    .alu_result(alu_result),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural AMO ALU: flops operands, little-endian lanes -------------
  function automatic logic [127:0] alu_model(input logic [3:0] op, input logic [39:0] addr,
                                             input logic [2:0] size, input logic [127:0] mem,
                                             input logic [127:0] cpu);
    int nb, off;
    logic [63:0] mask, a, b, sa, sb, r;
    nb   = (size >= 3'd1 && size <= 3'd4) ? (1 << (int'(size) - 1)) : 8;
    off  = int'(addr[3:0]) & ~(nb - 1);
    mask = (nb == 8) ? '1 : ((64'd1 << (nb * 8)) - 64'd1);
    a    = 64'(mem >> (off * 8)) & mask;
    b    = 64'(cpu >> (off * 8)) & mask;
    sa   = a;
    sb   = b;
    if (nb < 8) begin
      if (a[nb*8-1]) sa = a | ~mask;
      if (b[nb*8-1]) sb = b | ~mask;
    end
    case (op)
      OP_ADD:  r = a + b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MAX:  r = ($signed(sa) > $signed(sb)) ? a : b;
      OP_MAXU: r = (a > b) ? a : b;
      OP_MIN:  r = ($signed(sa) < $signed(sb)) ? a : b;
      OP_MINU: r = (a < b) ? a : b;
      default: r = a;
    endcase
    r = r & mask;
    return (mem & ~(128'(mask) << (off * 8))) | (128'(r) << (off * 8));
  endfunction

  logic [127:0] alu_mem_f = '0, alu_cpu_f = '0;
  always @(posedge clk) begin
    alu_mem_f <= alu_mem_operand;
    alu_cpu_f <= alu_cpu_operand;
  end
  always_comb alu_result = alu_model(alu_op, alu_addr, alu_size, alu_mem_f, alu_cpu_f);

  // ---------------- behavioural data array with programmable read latency --------------
  logic [127:0] mem_line = '0;
  int  rd_lat   = 1;
  int  pend     = 0;
  bit  suppress = 1'b0;

  initial forever begin
    @(negedge clk);
    arr_rd_data_val = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0 && !suppress) begin
        arr_rd_data     = mem_line;
        arr_rd_data_val = 1'b1;
      end
    end
    if (arr_rd_en) pend = rd_lat;
  end

  // ---------------- scoreboard ----------------------------------------------------------
  typedef struct {
    logic [127:0] data;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t wr_q[$];
  exp_t rsp_q[$];
  logic [39:0]  exp_addr = '0;
  int  n_wr_exp = 0, n_wr_seen = 0;
  int  resp_first = 0, last_hs = 0;
  bit  prev_val = 1'b0, prev_stall = 1'b0;
  logic [127:0] prev_data = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_val   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (arr_rd_en) chk("rd_addr", 128'(arr_addr), 128'(exp_addr));
      if (arr_wr_en) begin
        n_wr_seen++;
        if (wr_q.size() == 0) chk("unexpected_wr_en", 128'(arr_wr_en), 128'(0));
        else begin
          e = wr_q.pop_front();
          chk("wr_data", arr_wr_data, e.data);
          chk_int("wr_cycle", cyc, e.cyc);
          chk("wr_addr", 128'(arr_addr), 128'(exp_addr));
        end
      end
      if (resp_val) begin
        chk("req_rdy_during_resp", 128'(req_rdy), 128'(0));
        if (!prev_val) resp_first = cyc;
        if (prev_stall) chk("resp_data_stable", resp_data, prev_data);
        if (resp_rdy) begin
          last_hs = cyc;
          if (rsp_q.size() == 0) chk("unexpected_resp_val", 128'(resp_val), 128'(0));
          else begin
            e = rsp_q.pop_front();
            chk("resp_data", resp_data, e.data);
            chk("resp_err", 128'(resp_err), 128'(e.err));
            chk_int("resp_cycle", resp_first, e.cyc);
          end
        end
      end else if (prev_stall) begin
        chk("resp_val_stable", 128'(resp_val), 128'(1));
      end
      prev_val   = resp_val;
      prev_stall = resp_val && !resp_rdy;
      prev_data  = resp_data;
    end
  end

  // ---------------- driver --------------------------------------------------------------
  task automatic issue(input logic [3:0] op, input logic [39:0] addr, input logic [2:0] size,
                       input logic [127:0] cpu, input int lat, input bit push,
                       input bit do_wr, input logic [127:0] wr_line,
                       input logic [127:0] rsp_line, input logic rsp_err, input int rsp_off,
                       output int t_acc);
    int n;
    exp_t e;
    @(negedge clk);
    req_op   = op;
    req_addr = addr;
    req_size = size;
    req_data = cpu;
    req_val  = 1'b1;
    rd_lat   = lat;
    n = 0;
    while (!req_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    t_acc = cyc;
    if (!req_rdy) begin
      chk("req_accept", 128'(req_rdy), 128'(1));
      req_val = 1'b0;
      return;
    end
    exp_addr = addr;
    if (push) begin
      if (do_wr) begin
        e.data = wr_line; e.err = 1'b0; e.cyc = t_acc + lat + 3;
        wr_q.push_back(e);
        n_wr_exp++;
      end
      e.data = rsp_line; e.err = rsp_err; e.cyc = t_acc + rsp_off;
      rsp_q.push_back(e);
    end
    @(posedge clk);
    #1 req_val = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wr_q.size() != 0 || rsp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_int("drain_outstanding", wr_q.size() + rsp_q.size(), 0);
  endtask

  // ---------------- directed sequence ---------------------------------------------------
  localparam logic [127:0] L_ADD  = {64'hAAAA_BBBB_CCCC_DDDD, 64'h0000_0000_0000_0005};
  localparam logic [127:0] C_ADD  = {64'h0, 64'h0000_0000_0000_0003};
  localparam logic [127:0] W_ADD  = {64'hAAAA_BBBB_CCCC_DDDD, 64'h0000_0000_0000_0008};
  localparam logic [127:0] L_MIN  = 128'h1111_2222_3333_4444_FFFF_FFFE_5555_6666;
  localparam logic [127:0] C_MIN  = 128'h0000_0000_0000_0000_0000_0001_0000_0000;
  localparam logic [127:0] W_MINU = 128'h1111_2222_3333_4444_0000_0001_5555_6666;
  localparam logic [127:0] L_BP   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] C_XOR  = 128'h0000_0000_0000_0000_0000_0000_FF00_0000;
  localparam logic [127:0] W_XOR  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_8954_3210;
  localparam logic [127:0] C_OR   = 128'h0000_0000_0000_0000_0000_0000_0000_0C0F;
  localparam logic [127:0] W_OR   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3E1F;

  initial begin
    int t, t_b, n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_rdy",  128'(req_rdy),   128'(1));
    chk("rst_busy",     128'(busy),      128'(0));
    chk("rst_resp_val", 128'(resp_val),  128'(0));
    chk("rst_rd_en",    128'(arr_rd_en), 128'(0));
    chk("rst_wr_en",    128'(arr_wr_en), 128'(0));
    chk("rst_resp_err", 128'(resp_err),  128'(0));
    chk("rst_resp_data", resp_data,      128'(0));

    // ADD 8B, L=1: write t+4, response t+5
    mem_line = L_ADD;
    issue(OP_ADD, 40'h10_0000_1000, SZ8, C_ADD, 1, 1, 1, W_ADD, L_ADD, 1'b0, 5, t);
    drain();

    // MIN / MINU 4B on the upper word of dword0, L=2
    mem_line = L_MIN;
    issue(OP_MIN, 40'h00_0000_1004, SZ4, C_MIN, 2, 1, 1, L_MIN, L_MIN, 1'b0, 6, t);
    drain();
    issue(OP_MINU, 40'h00_0000_1004, SZ4, C_MIN, 2, 1, 1, W_MINU, L_MIN, 1'b0, 6, t);
    drain();

    // NOP, L=3: pure read, response at t+7, no write
    mem_line = L_BP;
    issue(OP_NOP, 40'h00_0000_3000, SZ8, C_ADD, 3, 1, 0, '0, L_BP, 1'b0, 7, t);
    drain();

    // Backpressure: 10 stall cycles, second request held until the response completes
    @(posedge clk);
    #1 resp_rdy = 1'b0;
    issue(OP_XOR, 40'h00_0000_2003, SZ1, C_XOR, 1, 1, 1, W_XOR, L_BP, 1'b0, 5, t);
    fork
      begin
        n = 0;
        while (!resp_val && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp_resp_val_seen", 128'(resp_val), 128'(1));
        repeat (10) @(posedge clk);
        #1 resp_rdy = 1'b1;
      end
      begin
        issue(OP_OR, 40'h00_0000_2000, SZ2, C_OR, 1, 1, 1, W_OR, L_BP, 1'b0, 5, t_b);
      end
    join
    chk_int("bp_second_accept_cycle", t_b, last_hs + 1);
    drain();

    // Reset while in WAIT, then a stale read return: no write, no response
    issue(OP_ADD, 40'h00_0000_4000, SZ8, C_ADD, 5, 0, 0, '0, '0, 1'b0, 0, t);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_busy",     128'(busy),     128'(0));
      chk("post_rst_resp_val", 128'(resp_val), 128'(0));
      chk("post_rst_req_rdy",  128'(req_rdy),  128'(1));
    end
    mem_line = L_ADD;
    issue(OP_ADD, 40'h10_0000_1000, SZ8, C_ADD, 1, 1, 1, W_ADD, L_ADD, 1'b0, 5, t);
    drain();

`ifdef L2_AMO_CTRL_TIMEOUT_EN
    // No read return: abort after 4 WAIT cycles, response at t+6
    suppress = 1'b1;
    issue(OP_ADD, 40'h00_0000_5000, SZ8, C_ADD, 1, 1, 0, '0, '0, 1'b1, 6, t);
    drain();
    repeat (3) @(negedge clk);
    suppress = 1'b0;
    // Data on the 4th WAIT cycle beats the timeout
    mem_line = L_ADD;
    issue(OP_ADD, 40'h10_0000_1000, SZ8, C_ADD, 4, 1, 1, W_ADD, L_ADD, 1'b0, 8, t);
    drain();
`endif

    repeat (4) @(negedge clk);
    chk_int("write_count", n_wr_seen, n_wr_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
    $fatal(1, "watchdog");
  end

endmodule
